// File: rtl/olive_irqctl_pkg.sv
// rtl/olive_irqctl_pkg.sv - register map and shared constants for the interrupt controller
package olive_irqctl_pkg;
  localparam logic [2:0] IRQCTL_ADDR_RAW     = 3'd0;
  localparam logic [2:0] IRQCTL_ADDR_PENDING = 3'd1;
  localparam logic [2:0] IRQCTL_ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] IRQCTL_ADDR_EDGE    = 3'd3;
  localparam logic [2:0] IRQCTL_ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] IRQCTL_ADDR_SWSET   = 3'd5;

  localparam int IRQCTL_MAX_LINES     = 16;
  localparam int IRQCTL_VEC_VALID_BIT = 15;
endpackage

// File: rtl/olive_irqctl_prienc.sv
// rtl/olive_irqctl_prienc.sv - lowest-index-wins priority encoder, purely combinational
module olive_irqctl_prienc #(
  parameter int N = 8
) (
  input  logic [N-1:0] act,
  output logic         valid,
  output logic [3:0]   index
);
  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    index = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (act[i]) begin
        valid = 1'b1;
        index = 4'(i);
      end
    end
  end
endmodule

// File: rtl/olive_std_core_irqctl.sv
// rtl/olive_std_core_irqctl.sv - masked, prioritised level/edge interrupt controller
// Edge capture (in_qq, EDGE register) is built only when OLIVE_IRQCTL_EDGE_EN is defined.
module olive_std_core_irqctl
  import olive_irqctl_pkg::*;
#(
  parameter int IRQ_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IRQ_COUNT-1:0] irq_in,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [15:0]          writedata,
  output logic [15:0]          readdata,
  output logic                 irq
);
  localparam int N = IRQ_COUNT;

  logic [N-1:0] in_q, latch, enable, edge_sel, rise;
  logic [N-1:0] pend, act, wd, set_mask, clr_mask;
  logic         wr, vec_valid;
  logic [3:0]   vec_index;
  logic [15:0]  rd_nxt;
  logic         unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[N-1:0];
  assign unused_wd = ^writedata;

`ifdef OLIVE_IRQCTL_EDGE_EN
  logic [N-1:0] in_qq, edge_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_qq  <= '0;
      edge_q <= '0;
    end else begin
      in_qq <= in_q;
      if (wr && address == IRQCTL_ADDR_EDGE) edge_q <= wd;
    end
  end

  assign rise     = in_q & ~in_qq;
  assign edge_sel = edge_q;
`else
  assign rise     = '0;
  assign edge_sel = '0;
`endif

  assign set_mask = (rise & edge_sel) | ((wr && address == IRQCTL_ADDR_SWSET) ? wd : '0);
  assign clr_mask = (wr && address == IRQCTL_ADDR_PENDING) ? wd : '0;
  assign pend     = latch | (in_q & ~edge_sel);
  assign act      = pend & enable;

  olive_irqctl_prienc #(.N(N)) u_prienc (
    .act   (act),
    .valid (vec_valid),
    .index (vec_index)
  );

  always_comb begin
    rd_nxt = 16'h0000;
    case (address)
      IRQCTL_ADDR_RAW:     rd_nxt = 16'(in_q);
      IRQCTL_ADDR_PENDING: rd_nxt = 16'(pend);
      IRQCTL_ADDR_ENABLE:  rd_nxt = 16'(enable);
      IRQCTL_ADDR_EDGE:    rd_nxt = 16'(edge_sel);
      IRQCTL_ADDR_VECTOR: begin
        rd_nxt[IRQCTL_VEC_VALID_BIT] = vec_valid;
        rd_nxt[3:0]                  = vec_index;
      end
      default:             rd_nxt = 16'h0000;
    endcase
  end

  // Set is OR-ed after the clear so a same-cycle event is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_q     <= '0;
      latch    <= '0;
      enable   <= '0;
      readdata <= 16'h0000;
      irq      <= 1'b0;
    end else begin
      in_q     <= irq_in;
      latch    <= (latch & ~clr_mask) | set_mask;
      readdata <= rd_nxt;
      irq      <= |act;
      if (wr && address == IRQCTL_ADDR_ENABLE) enable <= wd;
    end
  end
endmodule
